// File: rtl/nes_pad_receiver.sv
// NES controller pad serial receiver: drives latch/clock pins, shifts in 8 active-low button bits.
// Optional macro NES_EDGE_DETECT_EN adds a per-poll newly-pressed vector on `pressed`.
module nes_pad_receiver #(
  parameter int LATCH_CYCLES = 302,
  parameter int HALF_CYCLES  = 151
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy,
  output logic [7:0] pressed
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] PHASE_ONE  = CW'(1);
  localparam logic [CW-1:0] PHASE_ZERO = CW'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_LO = 3'd2,
    S_CLK_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, snd_q;
  logic          nes_latch_q, nes_latch_d;
  logic          nes_clk_q, nes_clk_d;
  logic [7:0]    buttons_q, buttons_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          phase_last;

  assign phase_last = (phase_q == PHASE_ZERO);

  // Two-flop synchroniser; resets to the idle (released) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      snd_q   <= 1'b1;
    end else begin
      sync1_q <= nes_data;
      snd_q   <= sync1_q;
    end
  end

  // Next-state, counters, shift register and registered-output decode.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    case (state_q)
      S_IDLE: begin
        bit_d = 3'd0;
        if (start) begin
          state_d = S_LATCH;
          phase_d = LATCH_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        if (phase_last) begin
          shift_d[0] = ~snd_q;
          bit_d      = 3'd1;
          state_d    = S_CLK_LO;
          phase_d    = HALF_LOAD;
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
      S_CLK_LO: begin
        if (phase_last) begin
          state_d = S_CLK_HI;
          phase_d = HALF_LOAD;
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
      S_CLK_HI: begin
        if (phase_last) begin
          shift_d[bit_q] = ~snd_q;
          if (bit_q == 3'd7) begin
            state_d = S_DONE;
            phase_d = PHASE_ZERO;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = S_CLK_LO;
            phase_d = HALF_LOAD;
          end
        end else begin
          phase_d = phase_q - PHASE_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = PHASE_ZERO;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = PHASE_ZERO;
      end
    endcase
    // Outputs decode the upcoming state so pins change in the same cycle as the state.
    nes_latch_d = (state_d == S_LATCH);
    nes_clk_d   = (state_d == S_CLK_HI);
    valid_d     = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_DONE) begin
      buttons_d = shift_d;
    end else begin
      buttons_d = buttons_q;
    end
  end

  // Main state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= PHASE_ZERO;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      nes_latch_q <= 1'b0;
      nes_clk_q   <= 1'b0;
      buttons_q   <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      nes_latch_q <= nes_latch_d;
      nes_clk_q   <= nes_clk_d;
      buttons_q   <= buttons_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef NES_EDGE_DETECT_EN
  logic [7:0] prev_q, prev_d;
  logic [7:0] pressed_q, pressed_d;

  // Newly-pressed vector relative to the previous completed poll.
  always_comb begin
    if (valid_d) begin
      pressed_d = shift_d & ~prev_q;
      prev_d    = shift_d;
    end else begin
      pressed_d = pressed_q;
      prev_d    = prev_q;
    end
  end

  // Edge-detect history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 8'h00;
      pressed_q <= 8'h00;
    end else begin
      prev_q    <= prev_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;
`else
  assign pressed = 8'h00;
`endif

  assign nes_latch = nes_latch_q;
  assign nes_clk   = nes_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_receiver.sv
// Self-checking bench for nes_pad_receiver with a behavioural 4021-style pad model.
// Honours NES_EDGE_DETECT_EN for the expected `pressed` values.
module tb_nes_pad_receiver;

  localparam int L    = 4;
  localparam int H    = 4;
  localparam int VCYC = L + 14 * H + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk, valid, busy;
  logic [7:0] buttons, pressed;

  logic [7:0] pad_btn = 8'h00;
  logic [3:0] pad_idx = 4'd8;
  logic       pad_out;
  logic       force_en = 1'b1;
  logic       force_val = 1'b1;
  logic [7:0] ref_prev = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  nes_pad_receiver #(.LATCH_CYCLES(L), .HALF_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nes_data(nes_data),
    .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
    .valid(valid), .busy(busy), .pressed(pressed)
  );

  always #5 clk = ~clk;

  // Pad: latch selects bit 0 (A); each nes_clk rise advances one button; line is active-low.
  always @(posedge nes_latch) pad_idx = 4'd0;
  always @(posedge nes_clk) if (pad_idx < 4'd8) pad_idx = pad_idx + 4'd1;
  always_comb pad_out = (pad_idx < 4'd8) ? ~pad_btn[pad_idx[2:0]] : 1'b1;
  assign nes_data = force_en ? force_val : pad_out;

  typedef struct {
    logic [7:0] btn;
    logic [7:0] exp_buttons;
    logic [7:0] exp_pressed;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full poll; optional extra start pulses at cycles 10 and 61 must be ignored.
  task automatic do_poll(input logic [7:0] btn, input logic [7:0] exp_b,
                         input logic [7:0] exp_p, input bit extra_starts);
    int   latch_bad, latch_rises, clk_rises, valid_at, valid_cnt, busy_bad;
    logic prev_latch, prev_clk;
    latch_bad = 0; latch_rises = 0; clk_rises = 0;
    valid_at = -1; valid_cnt = 0; busy_bad = 0;
    prev_latch = 1'b0; prev_clk = 1'b0;
    pad_btn = btn;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= VCYC; c++) begin
      if (nes_latch !== ((c <= L) ? 1'b1 : 1'b0)) latch_bad++;
      if (nes_latch === 1'b1 && prev_latch === 1'b0) latch_rises++;
      if (nes_clk === 1'b1 && prev_clk === 1'b0) clk_rises++;
      if (valid === 1'b1) begin
        valid_cnt++;
        if (valid_at < 0) valid_at = c;
      end
      if (busy !== 1'b1) busy_bad++;
      prev_latch = nes_latch;
      prev_clk   = nes_clk;
      start = (extra_starts && (c == 10 || c == VCYC)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("latch_window", latch_bad, 0);
    check("latch_pulses", latch_rises, 1);
    check("clk_rises", clk_rises, 7);
    check("valid_cycle", valid_at, VCYC);
    check("valid_width", valid_cnt, 1);
    check("busy_window", busy_bad, 0);
    check("buttons", buttons, exp_b);
    check("pressed", pressed, exp_p);
    check("idle_after", {nes_latch, valid, busy}, 3'b000);
  endtask

  function automatic logic [7:0] exp_press(input logic [7:0] now, input logic [7:0] prev);
`ifdef NES_EDGE_DETECT_EN
    return now & ~prev;
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    logic [7:0] b;
    int vcnt;

    tbl[0] = '{8'h81, 8'h81, exp_press(8'h81, 8'h00)};
    tbl[1] = '{8'hFF, 8'hFF, exp_press(8'hFF, 8'h81)};
    tbl[2] = '{8'h00, 8'h00, exp_press(8'h00, 8'hFF)};
    tbl[3] = '{8'h01, 8'h01, exp_press(8'h01, 8'h00)};
    tbl[4] = '{8'h01, 8'h01, exp_press(8'h01, 8'h01)};
    tbl[5] = '{8'h11, 8'h11, exp_press(8'h11, 8'h01)};

    // Reset with random line activity, then idle without start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      force_val = 1'($urandom);
      check("reset_outputs", {nes_latch, nes_clk, valid, busy, buttons, pressed}, 20'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      force_val = 1'($urandom);
      check("idle_outputs", {nes_latch, nes_clk, valid, busy, buttons, pressed}, 20'h0);
    end
    force_en = 1'b0;
    repeat (3) @(posedge clk);

    // Directed poll table.
    for (int i = 0; i < 6; i++) begin
      do_poll(tbl[i].btn, tbl[i].exp_buttons, tbl[i].exp_pressed, 1'b0);
    end
`ifndef NES_EDGE_DETECT_EN
    check("pressed_tied", pressed, 8'h00);
`endif
    repeat (4) @(posedge clk);
    #1 check("buttons_hold", buttons, 8'h11);

    // Starts while busy are dropped; start right after DONE begins a new poll.
    do_poll(8'h3C, 8'h3C, exp_press(8'h3C, 8'h11), 1'b1);
    do_poll(8'hC3, 8'hC3, exp_press(8'hC3, 8'h3C), 1'b0);

    // Reset in the middle of a poll.
    pad_btn = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midreset_outputs", {nes_latch, nes_clk, valid, busy, buttons, pressed}, 20'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (valid === 1'b1 || nes_latch === 1'b1) vcnt++;
    end
    check("no_activity_after_reset", vcnt, 0);
    do_poll(8'h5A, 8'h5A, exp_press(8'h5A, 8'h00), 1'b0);
    ref_prev = 8'h5A;

    // Randomised polls against the reference.
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      do_poll(b, b, exp_press(b, ref_prev), 1'b0);
      ref_prev = b;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
